// File: rtl/circle_sched_pkg.sv
// Shared types for the circle hit scheduler: slot record and scheduler states.
package circle_sched_pkg;

    localparam int unsigned CIRCLE_COORD_W = 12;

    typedef struct packed {
        logic [CIRCLE_COORD_W-1:0] x;
        logic [CIRCLE_COORD_W-1:0] y;
        logic [CIRCLE_COORD_W-1:0] r;
        logic                      en;
    } circle_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        RESP
    } sched_state_e;

endpackage

// File: rtl/circle_test_pipe.sv
// Two-stage point-in-circle tester: |dx|,|dy| then squares, followed by a
// combinational radius compare. Valid and tag travel alongside the data.
module circle_test_pipe #(
    parameter int unsigned COORD_W = 12,
    parameter int unsigned IDX_W   = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               in_valid_i,
    input  logic [IDX_W-1:0]   in_tag_i,
    input  logic [COORD_W-1:0] in_px_i,
    input  logic [COORD_W-1:0] in_py_i,
    input  logic [COORD_W-1:0] in_cx_i,
    input  logic [COORD_W-1:0] in_cy_i,
    input  logic [COORD_W-1:0] in_r_i,
    input  logic               in_en_i,
    output logic               out_valid_o,
    output logic [IDX_W-1:0]   out_tag_o,
    output logic               out_hit_o
);

    localparam int unsigned SQ_W = 2 * COORD_W;

    logic [COORD_W-1:0] dx_abs, dy_abs;

    logic               s1_valid_q, s1_en_q;
    logic [IDX_W-1:0]   s1_tag_q;
    logic [COORD_W-1:0] s1_dx_q, s1_dy_q, s1_r_q;

    logic               s2_valid_q, s2_en_q;
    logic [IDX_W-1:0]   s2_tag_q;
    logic [SQ_W-1:0]    s2_dx2_q, s2_dy2_q, s2_r2_q;

    logic [SQ_W:0]      dist2;

    always_comb begin
        dx_abs = (in_px_i >= in_cx_i) ? (in_px_i - in_cx_i) : (in_cx_i - in_px_i);
        dy_abs = (in_py_i >= in_cy_i) ? (in_py_i - in_cy_i) : (in_cy_i - in_py_i);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q <= 1'b0;
            s1_en_q    <= 1'b0;
            s1_tag_q   <= '0;
            s1_dx_q    <= '0;
            s1_dy_q    <= '0;
            s1_r_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_en_q    <= 1'b0;
            s2_tag_q   <= '0;
            s2_dx2_q   <= '0;
            s2_dy2_q   <= '0;
            s2_r2_q    <= '0;
        end else begin
            s1_valid_q <= in_valid_i;
            s1_en_q    <= in_en_i;
            s1_tag_q   <= in_tag_i;
            s1_dx_q    <= dx_abs;
            s1_dy_q    <= dy_abs;
            s1_r_q     <= in_r_i;
            s2_valid_q <= s1_valid_q;
            s2_en_q    <= s1_en_q;
            s2_tag_q   <= s1_tag_q;
            s2_dx2_q   <= SQ_W'(s1_dx_q) * SQ_W'(s1_dx_q);
            s2_dy2_q   <= SQ_W'(s1_dy_q) * SQ_W'(s1_dy_q);
            s2_r2_q    <= SQ_W'(s1_r_q) * SQ_W'(s1_r_q);
        end
    end

    // One extra bit on the sum so two full-scale squares cannot wrap.
    assign dist2       = {1'b0, s2_dx2_q} + {1'b0, s2_dy2_q};
    assign out_valid_o = s2_valid_q;
    assign out_tag_o   = s2_tag_q;
    assign out_hit_o   = s2_en_q && (dist2 <= {1'b0, s2_r2_q});

endmodule

// File: rtl/circle_hit_scheduler.sv
// Time-shares one circle tester across a programmable slot table and returns
// a hit mask, any-hit flag and first-hit index on a valid/ready port.
module circle_hit_scheduler
    import circle_sched_pkg::*;
#(
    parameter int unsigned NUM_CIRCLES = 4,
    parameter int unsigned COORD_W     = CIRCLE_COORD_W,
    parameter int unsigned IDX_W       = (NUM_CIRCLES > 1) ? $clog2(NUM_CIRCLES) : 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   cfg_we,
    input  logic [IDX_W-1:0]       cfg_idx,
    input  logic [COORD_W-1:0]     cfg_x,
    input  logic [COORD_W-1:0]     cfg_y,
    input  logic [COORD_W-1:0]     cfg_r,
    input  logic                   cfg_en,
    input  logic                   q_valid,
    output logic                   q_ready,
    input  logic [COORD_W-1:0]     q_x,
    input  logic [COORD_W-1:0]     q_y,
    output logic                   r_valid,
    input  logic                   r_ready,
    output logic [NUM_CIRCLES-1:0] r_hit_mask,
    output logic                   r_any,
    output logic [IDX_W-1:0]       r_first_idx
);

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] r;
        logic               en;
    } slot_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CIRCLES - 1);

    slot_t                  slots_q [NUM_CIRCLES];
    sched_state_e           state_q;
    logic [IDX_W-1:0]       cnt_q;
    logic [COORD_W-1:0]     qx_q, qy_q;
    logic                   iss_valid_q;
    logic [IDX_W-1:0]       iss_tag_q;
    slot_t                  iss_slot_q;
    logic [NUM_CIRCLES-1:0] mask_q, mask_d;
    logic                   any_q, q_ready_q, r_valid_q;
    logic [IDX_W-1:0]       first_q, first_d;
    logic                   res_valid, res_hit, found;
    logic [IDX_W-1:0]       res_tag;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NUM_CIRCLES; i++) begin
                slots_q[i] <= '0;
            end
        end else if (cfg_we && (32'(cfg_idx) < NUM_CIRCLES)) begin
            slots_q[cfg_idx] <= slot_t'{x: cfg_x, y: cfg_y, r: cfg_r, en: cfg_en};
        end
    end

    circle_test_pipe #(
        .COORD_W (COORD_W),
        .IDX_W   (IDX_W)
    ) u_test_pipe (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid_i  (iss_valid_q),
        .in_tag_i    (iss_tag_q),
        .in_px_i     (qx_q),
        .in_py_i     (qy_q),
        .in_cx_i     (iss_slot_q.x),
        .in_cy_i     (iss_slot_q.y),
        .in_r_i      (iss_slot_q.r),
        .in_en_i     (iss_slot_q.en),
        .out_valid_o (res_valid),
        .out_tag_o   (res_tag),
        .out_hit_o   (res_hit)
    );

    // Mask including the result arriving this cycle, so RESP entry sees the last bit.
    always_comb begin
        mask_d  = mask_q;
        first_d = '0;
        found   = 1'b0;
        if (res_valid) begin
            mask_d[res_tag] = res_hit;
        end
        for (int unsigned i = 0; i < NUM_CIRCLES; i++) begin
            if (mask_d[i] && !found) begin
                first_d = IDX_W'(i);
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            qx_q        <= '0;
            qy_q        <= '0;
            iss_valid_q <= 1'b0;
            iss_tag_q   <= '0;
            iss_slot_q  <= '0;
            mask_q      <= '0;
            any_q       <= 1'b0;
            first_q     <= '0;
            q_ready_q   <= 1'b1;
            r_valid_q   <= 1'b0;
        end else begin
            iss_valid_q <= 1'b0;
            mask_q      <= mask_d;
            unique case (state_q)
                IDLE: begin
                    if (q_valid && q_ready_q) begin
                        qx_q      <= q_x;
                        qy_q      <= q_y;
                        cnt_q     <= '0;
                        mask_q    <= '0;
                        q_ready_q <= 1'b0;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    iss_valid_q <= 1'b1;
                    iss_tag_q   <= cnt_q;
                    iss_slot_q  <= slots_q[cnt_q];
                    if (cnt_q == LAST_IDX) begin
                        state_q <= DRAIN;
                    end else begin
                        cnt_q <= cnt_q + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    if (res_valid && (res_tag == LAST_IDX)) begin
                        any_q     <= |mask_d;
                        first_q   <= first_d;
                        r_valid_q <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    if (r_ready) begin
                        r_valid_q <= 1'b0;
                        q_ready_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign q_ready     = q_ready_q;
    assign r_valid     = r_valid_q;
    assign r_hit_mask  = mask_q;
    assign r_any       = any_q;
    assign r_first_idx = first_q;

endmodule

// File: tb/tb_circle_hit_scheduler.sv
// Randomised bench for circle_hit_scheduler against an edge-counting reference model.
module tb_circle_hit_scheduler;
    import circle_sched_pkg::*;

    localparam int N  = 4;
    localparam int W  = 12;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [W-1:0]  cfg_x = '0, cfg_y = '0, cfg_r = '0;
    logic          cfg_en = 1'b0;
    logic          q_valid = 1'b0;
    logic          q_ready;
    logic [W-1:0]  q_x = '0, q_y = '0;
    logic          r_valid;
    logic          r_ready = 1'b0;
    logic [N-1:0]  r_hit_mask;
    logic          r_any;
    logic [IW-1:0] r_first_idx;

    int checks = 0;
    int errors = 0;

    circle_hit_scheduler #(
        .NUM_CIRCLES (N),
        .COORD_W     (W),
        .IDX_W       (IW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_x       (cfg_x),
        .cfg_y       (cfg_y),
        .cfg_r       (cfg_r),
        .cfg_en      (cfg_en),
        .q_valid     (q_valid),
        .q_ready     (q_ready),
        .q_x         (q_x),
        .q_y         (q_y),
        .r_valid     (r_valid),
        .r_ready     (r_ready),
        .r_hit_mask  (r_hit_mask),
        .r_any       (r_any),
        .r_first_idx (r_first_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slot table, point latched at accept, mask built from
    // the table contents seen at each slot's issue edge (accept edge + 1 + i).
    circle_t      m_tab [N];
    bit           m_busy, m_resp;
    int           m_k, m_px, m_py;
    bit [N-1:0]   m_mask;

    function automatic bit m_hit(circle_t c, int px, int py);
        longint dx, dy;
        dx = longint'(px) - longint'(c.x);
        dy = longint'(py) - longint'(c.y);
        return c.en && (dx * dx + dy * dy <= longint'(c.r) * longint'(c.r));
    endfunction

    function automatic int m_first(bit [N-1:0] m);
        for (int i = 0; i < N; i++) if (m[i]) return i;
        return 0;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_busy = 1'b0;
            m_resp = 1'b0;
            m_k    = 0;
            m_mask = '0;
            for (int i = 0; i < N; i++) m_tab[i] = '0;
        end else begin
            if (m_resp) begin
                if (r_ready) m_resp = 1'b0;
            end else if (m_busy) begin
                m_k++;
                if (m_k <= N) m_mask[m_k-1] = m_hit(m_tab[m_k-1], m_px, m_py);
                if (m_k == N + 3) begin
                    m_busy = 1'b0;
                    m_resp = 1'b1;
                end
            end else if (q_valid) begin
                m_busy = 1'b1;
                m_k    = 0;
                m_mask = '0;
                m_px   = int'(q_x);
                m_py   = int'(q_y);
            end
            if (cfg_we && int'(cfg_idx) < N)
                m_tab[cfg_idx] = '{x: cfg_x, y: cfg_y, r: cfg_r, en: cfg_en};
        end
    end

    always @(posedge clk) begin
        #1;
        check("cmp_q_ready", q_ready, !m_busy && !m_resp);
        check("cmp_r_valid", r_valid, m_resp);
        if (m_resp) begin
            check("cmp_mask", r_hit_mask, m_mask);
            check("cmp_any", r_any, |m_mask);
            check("cmp_first", r_first_idx, m_first(m_mask));
        end
    end

    task automatic drive_cfg(input int idx, input int x, input int y, input int r, input bit en);
        cfg_we  = 1'b1;
        cfg_idx = IW'(idx);
        cfg_x   = W'(x);
        cfg_y   = W'(y);
        cfg_r   = W'(r);
        cfg_en  = en;
    endtask

    task automatic cfg_write(input int idx, input int x, input int y, input int r, input bit en);
        @(negedge clk);
        drive_cfg(idx, x, y, r, en);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // race_slot >= 0: rewrite that slot on its issue edge; -2: random traffic while busy.
    task automatic run_query(input int x, input int y, input int hold, input int race_slot,
                             input circle_t race_val, output logic [N-1:0] mask,
                             output logic any, output logic [IW-1:0] first);
        int n;
        int lat;
        n = 0;
        @(negedge clk);
        while (!q_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", q_ready, 1);
        q_valid = 1'b1;
        q_x     = W'(x);
        q_y     = W'(y);
        @(negedge clk);
        q_valid = 1'b0;
        lat = 0;
        while (!r_valid && lat < 100) begin
            if (lat == race_slot) begin
                drive_cfg(race_slot, race_val.x, race_val.y, race_val.r, race_val.en);
            end else if (race_slot == -2 && $urandom_range(0, 2) == 0) begin
                drive_cfg($urandom_range(0, N - 1), $urandom_range(0, 600),
                          $urandom_range(0, 600), $urandom_range(0, 400), $urandom_range(0, 3) != 0);
            end else begin
                cfg_we = 1'b0;
            end
            if (race_slot == -2) begin
                q_valid = ($urandom_range(0, 1) == 1);
                q_x     = W'($urandom_range(0, 4095));
                q_y     = W'($urandom_range(0, 4095));
            end
            @(negedge clk);
            lat++;
        end
        cfg_we  = 1'b0;
        q_valid = 1'b0;
        check("latency", lat, N + 3);
        mask  = r_hit_mask;
        any   = r_any;
        first = r_first_idx;
        repeat (hold) begin
            check("hold_q_ready", q_ready, 0);
            check("hold_r_valid", r_valid, 1);
            check("hold_mask", r_hit_mask, mask);
            @(negedge clk);
        end
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        check("hs_q_ready", q_ready, 1);
        check("hs_r_valid", r_valid, 0);
    endtask

    initial begin
        logic [N-1:0]  mk;
        logic          an;
        logic [IW-1:0] fi;
        circle_t       rv;

        repeat (3) @(negedge clk);
        check("rst_q_ready", q_ready, 1);
        check("rst_r_valid", r_valid, 0);
        check("rst_mask", r_hit_mask, 0);
        check("rst_any", r_any, 0);
        check("rst_first", r_first_idx, 0);
        resetn = 1'b1;

        cfg_write(0, 100, 100, 10, 1'b1);
        run_query(106, 108, 0, -1, '0, mk, an, fi);
        check("t1_mask", mk, 4'b0001);
        check("t1_any", an, 1);
        check("t1_first", fi, 0);
        check("t1_model", m_mask, 4'b0001);

        run_query(110, 100, 0, -1, '0, mk, an, fi);
        check("t2_edge_mask", mk, 4'b0001);
        run_query(111, 100, 0, -1, '0, mk, an, fi);
        check("t2_out_mask", mk, 4'b0000);
        check("t2_out_any", an, 0);
        check("t2_out_first", fi, 0);

        cfg_write(1, 0, 0, 4095, 1'b1);
        cfg_write(3, 4095, 4095, 4095, 1'b1);
        run_query(4095, 0, 0, -1, '0, mk, an, fi);
        check("t3_mask", mk, 4'b1010);
        check("t3_first", fi, 1);
        check("t3_any", an, 1);

        run_query(4095, 0, 20, -1, '0, mk, an, fi);
        check("t4_mask", mk, 4'b1010);

        cfg_write(2, 2000, 2000, 100, 1'b0);
        run_query(2000, 2000, 0, -1, '0, mk, an, fi);
        check("t5_disabled_mask", mk, 4'b1010);
        cfg_write(2, 2000, 2000, 100, 1'b1);
        rv = '{x: 12'd2000, y: 12'd2000, r: 12'd100, en: 1'b0};
        run_query(2000, 2000, 0, 2, rv, mk, an, fi);
        check("t5_race_mask", mk, 4'b1110);
        check("t5_race_model", m_mask, 4'b1110);
        run_query(2000, 2000, 0, -1, '0, mk, an, fi);
        check("t5_after_mask", mk, 4'b1010);

        @(negedge clk);
        q_valid = 1'b1;
        q_x     = W'(2000);
        q_y     = W'(2000);
        @(negedge clk);
        q_valid = 1'b0;
        repeat (N + 1) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("t6_r_valid", r_valid, 0);
        check("t6_q_ready", q_ready, 1);
        check("t6_mask", r_hit_mask, 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        run_query(0, 0, 0, -1, '0, mk, an, fi);
        check("t6_cleared_mask", mk, 4'b0000);
        cfg_write(0, 100, 100, 10, 1'b1);
        run_query(106, 108, 0, -1, '0, mk, an, fi);
        check("t6_rerun_mask", mk, 4'b0001);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1)
                cfg_write($urandom_range(0, N - 1), $urandom_range(0, 600), $urandom_range(0, 600),
                          $urandom_range(0, 400), $urandom_range(0, 3) != 0);
            @(negedge clk);
            r_ready = 1'b1;
            @(negedge clk);
            r_ready = 1'b0;
            run_query($urandom_range(0, 600), $urandom_range(0, 600), $urandom_range(0, 3),
                      (it % 3 == 0) ? -1 : -2, '0, mk, an, fi);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
